ps2_key_decoder: RTL and testbench
==================================

Name: ps2_key_decoder

Overview:
- Sits directly downstream of the PS/2 serial receiver and consumes its stream of validated scancode bytes.
- Resolves the E0 (extended) and F0 (break) prefixes into complete key events.
- Tracks modifier and lock state, translates the scancode to ASCII, counts distinct key presses, and queues events in a small FIFO with a valid/ready output for the MMIO/CPU side.
- Also drives display-facing registers (last scancode, last ASCII, press count) for the seven-segment path.

Parameters:
- FIFO_DEPTH, 8, number of event entries; power of two, at least 2.
- CNT_W, 8, width of the key press counter.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- byte_valid  in  1  one-cycle pulse per received byte
- byte_data  in  8  received scancode byte, valid while byte_valid=1
- evt_valid  out  1  FIFO head holds an event
- evt_ready  in  1  consumer accepts head this cycle
- evt_scancode  out  8  head scancode (prefixes stripped)
- evt_ext  out  1  head was E0-prefixed
- evt_break  out  1  head is a release (F0)
- evt_ascii  out  8  head ASCII; 0x00 if unmapped
- last_scancode  out  8  scancode of most recent make event
- last_ascii  out  8  ASCII of most recent make event
- key_count  out  CNT_W  number of distinct (non-repeat) presses
- shift  out  1  left or right shift currently held
- caps  out  1  caps-lock toggle state
- overflow  out  1  sticky: an event was dropped
- ovf_clr  in  1  clears overflow

Behaviour:
- Reset: asynchronous and active-high. All outputs are 0; FSM goes to IDLE; FIFO is empty; held_valid=0.
- FSM states are IDLE, EXT, BRK, EXT_BRK. The FSM advances only on byte_valid.
  - IDLE: E0->EXT; F0->BRK; 0x00/0xFF->IDLE with no event; any other byte emits make(ext=0).
  - EXT: E0->EXT; F0->EXT_BRK; 0x00/0xFF->IDLE with no event; any other byte emits make(ext=1) and returns to IDLE.
  - BRK: F0->BRK; E0->EXT_BRK; 0x00/0xFF->IDLE; any other byte emits break(ext=0) and returns to IDLE.
  - EXT_BRK: E0/F0->EXT_BRK; 0x00/0xFF->IDLE; any other byte emits break(ext=1) and returns to IDLE.
- Emit timing: when byte_valid is high in cycle N, the FIFO write, modifier, counter and last_* updates all take effect at the end of cycle N. evt_valid is high in cycle N+1 if the FIFO was empty.
- Repeat detection: held_code/held_ext/held_valid track the last pressed key.
  - A make that matches the held key while held_valid=1 is a repeat. Repeats are queued but do not increment key_count and do not toggle caps.
  - A make that does not match updates held_* and sets held_valid=1.
  - A break that matches the held key clears held_valid.
- Modifiers:
  - Non-extended 0x12 sets/clears shift_l; non-extended 0x59 sets/clears shift_r; shift = shift_l | shift_r.
  - A non-repeat make of non-extended 0x58 toggles caps.
  - Modifier state at the emit cycle, before that event's own update, determines the ASCII stored.
- ASCII mapping:
  - Letters are lowercase; they are uppercase when shift XOR caps.
  - Digits 0-9 are unaffected by shift and caps.
  - 0x29->0x20, 0x5A->0x0D (including extended), 0x66->0x08, 0x0D->0x09.
  - Every other code, and every other extended code, maps to 0x00.
  - Break events carry the same ASCII as the corresponding make.
- key_count wraps modulo 2^CNT_W. last_scancode and last_ascii update on every make, repeats included.
- FIFO:
  - Pop occurs when evt_valid & evt_ready.
  - When full with no pop, the new event is dropped and overflow is set.
  - When full with a simultaneous pop, both push and pop occur and nothing is dropped.
  - evt_* reflect the head combinationally from storage.
  - When ovf_clr and a new drop occur in the same cycle, overflow stays 1.
- Reset mid-sequence (for example after E0): the partial prefix is discarded and queued events are lost.

Decomposition:
- Package ps2_pkg holds:
  - FSM state encoding.
  - Constants SC_EXT=0xE0, SC_BRK=0xF0, SC_LSHIFT=0x12, SC_RSHIFT=0x59, SC_CAPS=0x58, SC_ERR0=0x00, SC_ERR1=0xFF.
  - Event struct {scancode, ext, brk, ascii}.
- Sub-module ps2_ascii_lut is purely combinational: inputs scancode, ext, upper; output ascii.
- The FIFO is inline; a generic sync_fifo may be reused if one is present.

Test Plan:
- Bytes 1C, F0 1C with evt_ready=1 -> events {1C, ext=0, brk=0, ascii=0x61} then {1C, brk=1, ascii=0x61}; key_count=1.
- Bytes 12, 1C, F0 12 -> second event ascii=0x41; shift=1 after 12 and 0 after F0 12.
- Bytes 58, F0 58, 1C -> caps=1; 1C event ascii=0x41. Bytes 58 58 58 (typematic) -> caps toggles once; key_count +1.
- Bytes E0 75, E0 F0 75 -> {75, ext=1, brk=0, ascii=0}, {75, ext=1, brk=1}. Bytes E0 5A -> ascii=0x0D.
- evt_ready=0, push 9 makes (DEPTH=8) -> overflow=1, FIFO holds the first 8; pulse ovf_clr -> overflow=0. With the FIFO full, push and pop in the same cycle -> no drop.
- Byte E0, then assert reset, then byte 1C -> event {1C, ext=0}; all outputs are 0 during reset. Byte FF inside F0 -> no event; FSM returns to IDLE.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scancode-to-key-event decoder.
// Covers the prefix FSM encoding, special scancodes and the queued event record.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_t;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_ERR0   = 8'h00;
  localparam logic [7:0] SC_ERR1   = 8'hFF;

  typedef struct packed {
    logic [7:0] scancode;
    logic       ext;
    logic       brk;
    logic [7:0] ascii;
  } ps2_evt_t;

  // Keyboard error/overrun bytes abort any prefix sequence in progress.
  function automatic logic is_err_code(input logic [7:0] code);
    return (code == SC_ERR0) || (code == SC_ERR1);
  endfunction

endpackage

// File: rtl/ps2_ascii_lut.sv
// Combinational set-2 scancode to ASCII translation.
// Letters honour the upper-case request; digits and control keys ignore it.
module ps2_ascii_lut
  import ps2_pkg::*;
(
  input  logic [7:0] scancode,
  input  logic       ext,
  input  logic       upper,
  output logic [7:0] ascii
);

  logic [7:0] lower;
  logic       is_letter;

  always_comb begin
    lower = 8'h00;
    if (!ext) begin
      case (scancode)
        8'h1C: lower = 8'h61;  8'h32: lower = 8'h62;  8'h21: lower = 8'h63;
        8'h23: lower = 8'h64;  8'h24: lower = 8'h65;  8'h2B: lower = 8'h66;
        8'h34: lower = 8'h67;  8'h33: lower = 8'h68;  8'h43: lower = 8'h69;
        8'h3B: lower = 8'h6A;  8'h42: lower = 8'h6B;  8'h4B: lower = 8'h6C;
        8'h3A: lower = 8'h6D;  8'h31: lower = 8'h6E;  8'h44: lower = 8'h6F;
        8'h4D: lower = 8'h70;  8'h15: lower = 8'h71;  8'h2D: lower = 8'h72;
        8'h1B: lower = 8'h73;  8'h2C: lower = 8'h74;  8'h3C: lower = 8'h75;
        8'h2A: lower = 8'h76;  8'h1D: lower = 8'h77;  8'h22: lower = 8'h78;
        8'h35: lower = 8'h79;  8'h1A: lower = 8'h7A;
        8'h45: lower = 8'h30;  8'h16: lower = 8'h31;  8'h1E: lower = 8'h32;
        8'h26: lower = 8'h33;  8'h25: lower = 8'h34;  8'h2E: lower = 8'h35;
        8'h36: lower = 8'h36;  8'h3D: lower = 8'h37;  8'h3E: lower = 8'h38;
        8'h46: lower = 8'h39;
        8'h29: lower = 8'h20;  8'h5A: lower = 8'h0D;
        8'h66: lower = 8'h08;  8'h0D: lower = 8'h09;
        default: lower = 8'h00;
      endcase
    end else if (scancode == 8'h5A) begin
      // Keypad Enter is the only extended key with a character.
      lower = 8'h0D;
    end
  end

  assign is_letter = (lower >= 8'h61) && (lower <= 8'h7A);
  assign ascii     = (is_letter && upper) ? (lower - 8'h20) : lower;

endmodule

// File: rtl/ps2_key_decoder.sv
// Turns validated PS/2 scancode bytes into make/break key events with ASCII,
// modifier/lock tracking, a press counter and a small event FIFO.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       evt_scancode,
  output logic             evt_ext,
  output logic             evt_break,
  output logic [7:0]       evt_ascii,
  output logic [7:0]       last_scancode,
  output logic [7:0]       last_ascii,
  output logic [CNT_W-1:0] key_count,
  output logic             shift,
  output logic             caps,
  output logic             overflow,
  input  logic             ovf_clr
);

  localparam int              AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]     PTR_ONE = (AW+1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  ps2_state_t state, state_nxt;
  logic       emit_vld_p0, emit_ext_p0, emit_brk_p0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    emit_vld_p0 = 1'b0;
    emit_ext_p0 = 1'b0;
    emit_brk_p0 = 1'b0;
    if (byte_valid) begin
      if (is_err_code(byte_data)) begin
        state_nxt = ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (byte_data == SC_EXT)      state_nxt = ST_EXT;
            else if (byte_data == SC_BRK) state_nxt = ST_BRK;
            else                          emit_vld_p0 = 1'b1;
          end
          ST_EXT: begin
            if (byte_data == SC_EXT)      state_nxt = ST_EXT;
            else if (byte_data == SC_BRK) state_nxt = ST_EXT_BRK;
            else begin
              emit_vld_p0 = 1'b1;
              emit_ext_p0 = 1'b1;
              state_nxt   = ST_IDLE;
            end
          end
          ST_BRK: begin
            if (byte_data == SC_BRK)      state_nxt = ST_BRK;
            else if (byte_data == SC_EXT) state_nxt = ST_EXT_BRK;
            else begin
              emit_vld_p0 = 1'b1;
              emit_brk_p0 = 1'b1;
              state_nxt   = ST_IDLE;
            end
          end
          ST_EXT_BRK: begin
            if ((byte_data == SC_EXT) || (byte_data == SC_BRK)) begin
              state_nxt = ST_EXT_BRK;
            end else begin
              emit_vld_p0 = 1'b1;
              emit_ext_p0 = 1'b1;
              emit_brk_p0 = 1'b1;
              state_nxt   = ST_IDLE;
            end
          end
          default: state_nxt = ST_IDLE;
        endcase
      end
    end
  end

  // ---- stage p0: event classification against held key and modifiers ----
  logic [7:0] held_code;
  logic       held_ext, held_valid;
  logic       shift_l, shift_r;
  logic       held_match, is_make, is_brk_evt, is_repeat, upper;
  logic [7:0] ascii_p0;
  ps2_evt_t   evt_p0;

  assign shift      = shift_l | shift_r;
  assign upper      = shift ^ caps;
  assign held_match = (held_code == byte_data) && (held_ext == emit_ext_p0);
  assign is_make    = emit_vld_p0 && !emit_brk_p0;
  assign is_brk_evt = emit_vld_p0 && emit_brk_p0;
  assign is_repeat  = is_make && held_valid && held_match;

  ps2_ascii_lut u_lut (
    .scancode (byte_data),
    .ext      (emit_ext_p0),
    .upper    (upper),
    .ascii    (ascii_p0)
  );

  assign evt_p0 = '{scancode: byte_data, ext: emit_ext_p0, brk: emit_brk_p0, ascii: ascii_p0};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held_code     <= '0;
      held_ext      <= 1'b0;
      held_valid    <= 1'b0;
      shift_l       <= 1'b0;
      shift_r       <= 1'b0;
      caps          <= 1'b0;
      key_count     <= '0;
      last_scancode <= '0;
      last_ascii    <= '0;
    end else if (emit_vld_p0) begin
      if (!emit_ext_p0 && (byte_data == SC_LSHIFT)) shift_l <= !emit_brk_p0;
      if (!emit_ext_p0 && (byte_data == SC_RSHIFT)) shift_r <= !emit_brk_p0;
      if (is_make) begin
        last_scancode <= byte_data;
        last_ascii    <= ascii_p0;
      end
      if (is_make && !is_repeat) begin
        key_count  <= key_count + CNT_ONE;
        held_code  <= byte_data;
        held_ext   <= emit_ext_p0;
        held_valid <= 1'b1;
        if (!emit_ext_p0 && (byte_data == SC_CAPS)) caps <= ~caps;
      end else if (is_brk_evt && held_match) begin
        held_valid <= 1'b0;
      end
    end
  end

  // ---- stage p1: event FIFO ----
  ps2_evt_t    mem [FIFO_DEPTH];
  ps2_evt_t    head;
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, pop, push, drop;

  assign evt_valid = (wr_ptr != rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop       = evt_valid && evt_ready;
  assign push      = emit_vld_p0 && (!full || pop);
  assign drop      = emit_vld_p0 && full && !pop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= evt_p0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  // Head fields are masked while empty so stale storage never leaks out.
  assign head         = mem[rd_ptr[AW-1:0]];
  assign evt_scancode = evt_valid ? head.scancode : 8'h00;
  assign evt_ext      = evt_valid & head.ext;
  assign evt_break    = evt_valid & head.brk;
  assign evt_ascii    = evt_valid ? head.ascii : 8'h00;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Randomised and directed bench for ps2_key_decoder against a prefix/queue
// reference model built from the key-event rules.
module tb_ps2_key_decoder;

  localparam int DEPTH = 8;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             byte_valid = 1'b0;
  logic [7:0]       byte_data = 8'h00;
  logic             evt_ready = 1'b0;
  logic             ovf_clr = 1'b0;
  logic             evt_valid, evt_ext, evt_break, shift, caps, overflow;
  logic [7:0]       evt_scancode, evt_ascii, last_scancode, last_ascii;
  logic [CNT_W-1:0] key_count;

  ps2_key_decoder #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_scancode(evt_scancode),
    .evt_ext(evt_ext), .evt_break(evt_break), .evt_ascii(evt_ascii),
    .last_scancode(last_scancode), .last_ascii(last_ascii), .key_count(key_count),
    .shift(shift), .caps(caps), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  localparam logic [7:0] LETTER_SC [26] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A,
    8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  localparam logic [7:0] DIGIT_SC [10] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  function automatic logic [7:0] ref_ascii(input logic [7:0] sc, input logic ext, input logic up);
    if (ext) return (sc == 8'h5A) ? 8'h0D : 8'h00;
    for (int i = 0; i < 26; i++)
      if (LETTER_SC[i] == sc) return (up ? 8'h41 : 8'h61) + 8'(i);
    for (int i = 0; i < 10; i++)
      if (DIGIT_SC[i] == sc) return 8'h30 + 8'(i);
    case (sc)
      8'h29: return 8'h20;
      8'h5A: return 8'h0D;
      8'h66: return 8'h08;
      8'h0D: return 8'h09;
      default: return 8'h00;
    endcase
  endfunction

  typedef struct {
    logic [7:0] sc;
    logic       ext;
    logic       brk;
    logic [7:0] as;
  } mev_t;

  mev_t       m_q[$];
  logic       m_pext, m_pbrk, m_held_v, m_held_ext, m_shl, m_shr, m_caps, m_ovf;
  logic [7:0] m_held_code, m_last_sc, m_last_as;
  int         m_cnt;

  task automatic model_reset();
    m_q.delete();
    m_pext = 0; m_pbrk = 0; m_held_v = 0; m_held_ext = 0; m_held_code = 0;
    m_shl = 0; m_shr = 0; m_caps = 0; m_ovf = 0; m_cnt = 0;
    m_last_sc = 0; m_last_as = 0;
  endtask

  task automatic compare_all();
    chk("evt_valid", 32'(evt_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      chk("evt_scancode", 32'(evt_scancode), 32'(m_q[0].sc));
      chk("evt_ext", 32'(evt_ext), 32'(m_q[0].ext));
      chk("evt_break", 32'(evt_break), 32'(m_q[0].brk));
      chk("evt_ascii", 32'(evt_ascii), 32'(m_q[0].as));
    end
    chk("shift", 32'(shift), 32'(m_shl | m_shr));
    chk("caps", 32'(caps), 32'(m_caps));
    chk("key_count", 32'(key_count), 32'(m_cnt));
    chk("last_scancode", 32'(last_scancode), 32'(m_last_sc));
    chk("last_ascii", 32'(last_ascii), 32'(m_last_as));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  // One clock: drive inputs, compare against the model, advance the model.
  task automatic step(input logic bv, input logic [7:0] bd, input logic rdy, input logic clr);
    mev_t ev;
    logic pop, full, drop, rep;
    byte_valid = bv; byte_data = bd; evt_ready = rdy; ovf_clr = clr;
    #1;
    compare_all();
    drop = 0;
    full = (m_q.size() == DEPTH);
    pop  = (m_q.size() > 0) && rdy;
    if (pop) ev = m_q.pop_front();
    if (bv) begin
      if (bd == 8'h00 || bd == 8'hFF) begin
        m_pext = 0; m_pbrk = 0;
      end else if (bd == 8'hE0) begin
        m_pext = 1;
      end else if (bd == 8'hF0) begin
        m_pbrk = 1;
      end else begin
        ev.sc = bd; ev.ext = m_pext; ev.brk = m_pbrk;
        ev.as = ref_ascii(bd, m_pext, (m_shl | m_shr) ^ m_caps);
        if (!full || pop) m_q.push_back(ev);
        else drop = 1;
        rep = !ev.brk && m_held_v && m_held_code == bd && m_held_ext == ev.ext;
        if (!ev.ext && bd == 8'h12) m_shl = !ev.brk;
        if (!ev.ext && bd == 8'h59) m_shr = !ev.brk;
        if (!ev.brk) begin
          m_last_sc = bd; m_last_as = ev.as;
          if (!rep) begin
            m_cnt = (m_cnt + 1) % (1 << CNT_W);
            if (!ev.ext && bd == 8'h58) m_caps = !m_caps;
            m_held_v = 1; m_held_code = bd; m_held_ext = ev.ext;
          end
        end else if (m_held_code == bd && m_held_ext == ev.ext) begin
          m_held_v = 0;
        end
        m_pext = 0; m_pbrk = 0;
      end
    end
    if (drop) m_ovf = 1;
    else if (clr) m_ovf = 0;
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b, 1'b0, 1'b0);
  endtask

  task automatic pop_expect(input logic [7:0] sc, input logic ext, input logic brk, input logic [7:0] as);
    chk("pop_valid", 32'(evt_valid), 32'd1);
    chk("pop_scancode", 32'(evt_scancode), 32'(sc));
    chk("pop_ext", 32'(evt_ext), 32'(ext));
    chk("pop_break", 32'(evt_break), 32'(brk));
    chk("pop_ascii", 32'(evt_ascii), 32'(as));
    step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    byte_valid = 0; evt_ready = 0; ovf_clr = 0;
    #2 reset = 1'b1;
    #1;
    chk("rst_evt_valid", 32'(evt_valid), 32'd0);
    chk("rst_evt_scancode", 32'(evt_scancode), 32'd0);
    chk("rst_evt_ext", 32'(evt_ext), 32'd0);
    chk("rst_evt_break", 32'(evt_break), 32'd0);
    chk("rst_evt_ascii", 32'(evt_ascii), 32'd0);
    chk("rst_last_scancode", 32'(last_scancode), 32'd0);
    chk("rst_last_ascii", 32'(last_ascii), 32'd0);
    chk("rst_key_count", 32'(key_count), 32'd0);
    chk("rst_shift", 32'(shift), 32'd0);
    chk("rst_caps", 32'(caps), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    @(posedge clk); #3 reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
  endtask

  function automatic logic [7:0] rand_byte();
    int r = $urandom_range(0, 99);
    if (r < 10) return 8'hE0;
    if (r < 20) return 8'hF0;
    if (r < 23) return ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
    if (r < 33) begin
      case ($urandom_range(0, 2))
        0: return 8'h12;
        1: return 8'h59;
        default: return 8'h58;
      endcase
    end
    if (r < 50) return LETTER_SC[$urandom_range(0, 3)];
    if (r < 70) return LETTER_SC[$urandom_range(0, 25)];
    if (r < 80) return DIGIT_SC[$urandom_range(0, 9)];
    if (r < 88) begin
      case ($urandom_range(0, 3))
        0: return 8'h29;
        1: return 8'h5A;
        2: return 8'h66;
        default: return 8'h0D;
      endcase
    end
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    int kc;
    logic stall;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Plain make then break
    send(8'h1C); send(8'hF0); send(8'h1C);
    pop_expect(8'h1C, 0, 0, 8'h61);
    pop_expect(8'h1C, 0, 1, 8'h61);
    chk("count_after_1c", 32'(key_count), 32'd1);

    // Shift modifies the letter
    send(8'h12);
    chk("shift_held", 32'(shift), 32'd1);
    send(8'h1C); send(8'hF0); send(8'h12);
    chk("shift_released", 32'(shift), 32'd0);
    pop_expect(8'h12, 0, 0, 8'h00);
    pop_expect(8'h1C, 0, 0, 8'h41);
    pop_expect(8'h12, 0, 1, 8'h00);

    // Caps lock toggle and typematic repeat
    send(8'h58); send(8'hF0); send(8'h58);
    chk("caps_on", 32'(caps), 32'd1);
    send(8'h1C);
    pop_expect(8'h58, 0, 0, 8'h00);
    pop_expect(8'h58, 0, 1, 8'h00);
    pop_expect(8'h1C, 0, 0, 8'h41);
    kc = int'(key_count);
    send(8'h58); send(8'h58); send(8'h58);
    chk("caps_typematic", 32'(caps), 32'd0);
    chk("count_typematic", 32'(key_count), 32'((kc + 1) % 256));
    pop_expect(8'h58, 0, 0, 8'h00);
    pop_expect(8'h58, 0, 0, 8'h00);
    pop_expect(8'h58, 0, 0, 8'h00);
    send(8'hF0); send(8'h58);
    pop_expect(8'h58, 0, 1, 8'h00);

    // Extended keys
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE0); send(8'h5A);
    pop_expect(8'h75, 1, 0, 8'h00);
    pop_expect(8'h75, 1, 1, 8'h00);
    pop_expect(8'h5A, 1, 0, 8'h0D);

    // Overflow, clear, then full with simultaneous push/pop
    for (int i = 0; i < 9; i++) send(LETTER_SC[i]);
    chk("ovf_set", 32'(overflow), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_cleared", 32'(overflow), 32'd0);
    chk("full_head", 32'(evt_scancode), 32'h1C);
    step(1'b1, 8'h3B, 1'b1, 1'b0);
    chk("no_drop_ovf", 32'(overflow), 32'd0);
    for (int i = 1; i < 8; i++) pop_expect(LETTER_SC[i], 0, 0, 8'h61 + 8'(i));
    pop_expect(8'h3B, 0, 0, 8'h6A);

    // Reset mid-prefix discards the E0
    send(8'hE0);
    do_reset();
    send(8'h1C);
    pop_expect(8'h1C, 0, 0, 8'h61);

    // Error byte inside a break prefix
    send(8'hF0); send(8'hFF);
    chk("err_no_event", 32'(evt_valid), 32'd0);
    send(8'h1C);
    pop_expect(8'h1C, 0, 0, 8'h61);

    // Randomised traffic with stall phases
    stall = 0;
    for (int i = 0; i < 1500; i++) begin
      if (i % 40 == 0) stall = ($urandom_range(0, 2) == 0);
      if (i == 750) do_reset();
      step(($urandom_range(0, 9) < 6), rand_byte(),
           stall ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 29) == 0));
    end
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
